// File: rtl/fp_convert.sv
// rtl/fp_convert.sv - two-stage pipelined IEEE-style float format converter
module fp_convert #(
    parameter int NXI = 8,
    parameter int NMI = 23,
    parameter int NXO = 5,
    parameter int NMO = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NXI+NMI:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NXO+NMO:0]   out_data,
    output logic [3:0]         out_flags
);

    // Exponent datapath carries two headroom bits so rebias and carry never wrap.
    localparam int EW     = ((NXI > NXO) ? NXI : NXO) + 2;
    localparam int BIAS_I = (1 << (NXI - 1)) - 1;
    localparam int BIAS_O = (1 << (NXO - 1)) - 1;
    localparam logic signed [EW-1:0] BIAS_DIFF = EW'(BIAS_O - BIAS_I);
    localparam logic signed [EW-1:0] EXP_MAX_O = EW'((1 << NXO) - 1);

    logic           in_sign;
    logic [NXI-1:0] in_exp;
    logic [NMI-1:0] in_mant;
    logic [NMO-1:0] mant_top;
    logic           guard;
    logic           sticky;

    assign in_sign = in_data[NXI+NMI];
    assign in_exp  = in_data[NXI+NMI-1:NMI];
    assign in_mant = in_data[NMI-1:0];

    generate
        if (NMO >= NMI) begin : g_pad
            if (NMO > NMI) begin : g_wide
                assign mant_top = {in_mant, {(NMO-NMI){1'b0}}};
            end else begin : g_same
                assign mant_top = in_mant;
            end
            assign guard  = 1'b0;
            assign sticky = 1'b0;
        end else begin : g_round
            assign mant_top = in_mant[NMI-1 -: NMO];
            assign guard    = in_mant[NMI-NMO-1];
            if (NMI - NMO >= 2) begin : g_sticky
                assign sticky = |in_mant[NMI-NMO-2:0];
            end else begin : g_nosticky
                assign sticky = 1'b0;
            end
        end
    endgenerate

    // Stage 1 registers
    logic                 s1_valid_q, s1_valid_d;
    logic                 s1_sign_q, s1_sign_d;
    logic                 s1_nan_q, s1_nan_d;
    logic                 s1_inf_q, s1_inf_d;
    logic                 s1_zero_q, s1_zero_d;
    logic signed [EW-1:0] s1_exp_q, s1_exp_d;
    logic [NMO-1:0]       s1_mant_q, s1_mant_d;
    logic                 s1_inc_q, s1_inc_d;
    logic                 s1_inexact_q, s1_inexact_d;

    // Stage 2 (output) registers
    logic                 s2_valid_q, s2_valid_d;
    logic [NXO+NMO:0]     s2_data_q, s2_data_d;
    logic [3:0]           s2_flags_q, s2_flags_d;

    logic s1_adv;

    assign s1_adv    = !s2_valid_q || out_ready;
    assign in_ready  = !s1_valid_q || s1_adv;
    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_flags = s2_flags_q;

    always_comb begin
        logic exp_max;
        logic exp_zero;
        logic finite;
        exp_max      = &in_exp;
        exp_zero     = ~|in_exp;
        finite       = !exp_max && !exp_zero;

        s1_valid_d   = s1_valid_q;
        s1_sign_d    = s1_sign_q;
        s1_nan_d     = s1_nan_q;
        s1_inf_d     = s1_inf_q;
        s1_zero_d    = s1_zero_q;
        s1_exp_d     = s1_exp_q;
        s1_mant_d    = s1_mant_q;
        s1_inc_d     = s1_inc_q;
        s1_inexact_d = s1_inexact_q;

        if (in_ready) begin
            s1_valid_d   = in_valid;
            s1_sign_d    = in_sign;
            s1_nan_d     = exp_max && (|in_mant);
            s1_inf_d     = exp_max && !(|in_mant);
            s1_zero_d    = exp_zero;
            s1_exp_d     = $signed({{(EW-NXI){1'b0}}, in_exp}) + BIAS_DIFF;
            s1_mant_d    = mant_top;
            // A NaN payload whose top bits are zero must stay a NaN.
            if (exp_max && (|in_mant)) begin
                s1_mant_d[NMO-1] = 1'b1;
            end
            s1_inc_d     = finite && guard && (sticky || mant_top[0]);
            s1_inexact_d = finite && (guard || sticky);
        end
    end

    always_comb begin
        logic [NMO:0]         sum;
        logic signed [EW-1:0] e2;
        logic                 unf;
        logic                 ovf;
        sum = {1'b0, s1_mant_q} + {{NMO{1'b0}}, s1_inc_q};
        e2  = s1_exp_q + $signed({{(EW-1){1'b0}}, sum[NMO]});
        unf = e2[EW-1] || (e2 == '0);
        ovf = !e2[EW-1] && (e2 >= EXP_MAX_O);

        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_flags_d = s2_flags_q;

        if (s1_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                if (s1_nan_q) begin
                    s2_data_d  = {s1_sign_q, {NXO{1'b1}}, s1_mant_q};
                    s2_flags_d = 4'b1000;
                end else if (s1_inf_q) begin
                    s2_data_d  = {s1_sign_q, {NXO{1'b1}}, {NMO{1'b0}}};
                    s2_flags_d = 4'b0000;
                end else if (s1_zero_q) begin
                    s2_data_d  = {s1_sign_q, {(NXO+NMO){1'b0}}};
                    s2_flags_d = 4'b0000;
                end else if (unf) begin
                    s2_data_d  = {s1_sign_q, {(NXO+NMO){1'b0}}};
                    s2_flags_d = 4'b0011;
                end else if (ovf) begin
                    s2_data_d  = {s1_sign_q, {NXO{1'b1}}, {NMO{1'b0}}};
                    s2_flags_d = 4'b0101;
                end else begin
                    s2_data_d  = {s1_sign_q, e2[NXO-1:0], sum[NMO-1:0]};
                    s2_flags_d = {3'b000, s1_inexact_q};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_flags_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_flags_q <= s2_flags_d;
        end
    end

    always_ff @(posedge clk) begin
        s1_sign_q    <= s1_sign_d;
        s1_nan_q     <= s1_nan_d;
        s1_inf_q     <= s1_inf_d;
        s1_zero_q    <= s1_zero_d;
        s1_exp_q     <= s1_exp_d;
        s1_mant_q    <= s1_mant_d;
        s1_inc_q     <= s1_inc_d;
        s1_inexact_q <= s1_inexact_d;
    end

endmodule
